// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and bit-order constants for the serializer
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam bit MSB_FIRST = 1'b0;
  localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: WIDTH-bit shift register with parallel load, zero fill and serial tap
module piso_shift_core #(
  parameter int WIDTH = 4,
  parameter bit DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);
  import piso_pkg::*;
  logic [WIDTH-1:0] sr_q, sr_d;
  // load wins over shift so a zero-gap reload never mixes in the old word
  always_comb sr_d = load_i ? data_i : shift_i ? (DIR == LSB_FIRST ? sr_q >> 1 : sr_q << 1) : sr_q;
  // shift register state; fully shifted out it reads back as zero on the line
  always_ff @(posedge clk or posedge clr)
    if (clr) sr_q <= '0;
    else sr_q <= sr_d;
  assign bit_o = DIR == LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out transmitter with frame strobes
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);
  import piso_pkg::*;
  localparam int CW = $clog2(WIDTH);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fs_q, fs_d;
  logic          accept, last;
  assign last        = cnt_q == '0;
  assign load_ready  = state_q == IDLE || last;
  assign accept      = load_valid && load_ready;
  assign done        = state_q == SHIFT && last;
  assign ser_valid   = state_q == SHIFT;
  assign frame_start = fs_q;
  // next state: accept (re)starts a word, the last bit without accept returns to idle
  always_comb begin
    state_d = accept ? SHIFT : done ? IDLE : state_q;
    cnt_d   = accept ? CW'(WIDTH - 1) : (state_q == SHIFT && !last) ? cnt_q - CW'(1) : cnt_q;
    fs_d    = accept;
  end
  // FSM, bit counter and first-bit strobe registers
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
    end
  piso_shift_core #(.WIDTH(WIDTH), .DIR(LSB_FIRST)) u_core (
    .clk     (clk),
    .clr     (clr),
    .load_i  (accept),
    .shift_i (ser_valid),
    .data_i  (load_data),
    .bit_o   (ser_out)
  );
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench over three serializer configurations
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       lv[3];
  logic [7:0] ld[3];
  logic       lr[3], so[3], sv[3], fs[3], dn[3], rdy_m[3];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_d
    localparam int W = i == 2 ? 8 : 4;
    localparam bit L = i == 1;
    logic [2:0] q[$];
    int rem = 0;
    assign rdy_m[i] = rem <= 1;
    piso_serializer #(.WIDTH(W), .LSB_FIRST(L)) u_dut (
      .clk         (clk),
      .clr         (clr),
      .load_valid  (lv[i]),
      .load_ready  (lr[i]),
      .load_data   (ld[i][W-1:0]),
      .ser_out     (so[i]),
      .ser_valid   (sv[i]),
      .frame_start (fs[i]),
      .done        (dn[i])
    );
    always @(posedge clk or posedge clr)
      if (clr) begin
        q.delete();
        rem <= 0;
      end else if (lv[i] && rem <= 1) begin
        for (int k = 0; k < W; k++)
          q.push_back({k == 0, k == W - 1, L ? ld[i][k] : ld[i][W-1-k]});
        rem <= W;
      end else if (rem > 0) rem <= rem - 1;
    always @(negedge clk) begin
      check("ready", i, lr[i], rdy_m[i]);
      if (sv[i] && q.size() == 0) check("spurious", i, sv[i], 0);
      else if (sv[i]) begin
        check("bit", i, {fs[i], dn[i], so[i]}, q[0]);
        void'(q.pop_front());
      end else begin
        check("valid", i, sv[i], q.size() != 0);
        check("idle", i, {fs[i], dn[i], so[i]}, 0);
      end
    end
  end

  task automatic send(input int g, input logic [7:0] w);
    int t = 0;
    lv[g] = 1'b1;
    ld[g] = w;
    while (!rdy_m[g] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("timeout", g, rdy_m[g], 1);
    @(negedge clk);
  endtask

  task automatic idle(input int g, input int n);
    lv[g] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int g);
    for (int n = 0; n < 40; n++) begin
      send(g, 8'($urandom));
      idle(g, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      lv[g] = 1'b0;
      ld[g] = '0;
    end
    #1 clr = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_out", g, {so[g], sv[g], fs[g], dn[g]}, 0);
      check("rst_ready", g, lr[g], 1);
    end
    #2 clr = 1'b0;
    @(negedge clk);
    send(0, 8'hB); idle(0, 6);
    send(1, 8'hB); idle(1, 6);
    send(0, 8'hA); send(0, 8'h5); idle(0, 6);
    send(0, 8'h9);
    @(negedge clk);
    lv[0] = 1'b1;
    ld[0] = 8'hF;
    @(negedge clk);
    idle(0, 6);
    send(0, 8'hC); idle(0, 1);
    #2 clr = 1'b1;
    #1 check("abort_out", 0, {so[0], sv[0], fs[0], dn[0]}, 0);
    check("abort_ready", 0, lr[0], 1);
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    send(0, 8'h3); idle(0, 6);
    fork
      drive(0);
      drive(1);
      drive(2);
    join
    repeat (20) @(negedge clk);
    check("drain", 0, g_d[0].q.size(), 0);
    check("drain", 1, g_d[1].q.size(), 0);
    check("drain", 2, g_d[2].q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
